uart_frame_parser: RTL and testbench

- Receive-side counterpart of the UART frame packer. It consumes the byte strobe stream from the UART driver's receive port and decodes frames of the form HEAD, NUM, DATA_NUM payload bytes, TAIL.
- A complete, well-terminated frame is presented as a parallel word with a one-cycle valid pulse. Malformed or stalled frames raise a one-cycle error pulse with a cause code.
- Sits between UART_Driver (Rx_Data/Rx_ACK) and the command/control logic.

---
 rtl/uart_frame_parser_if.sv | 22 ++
 rtl/uart_frame_parser.sv | 119 +++++++++++
 tb/tb_uart_frame_parser.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Receive-byte handshake and decoded-frame bus of the UART frame parser.
// The driver side is the master, the parser is the slave.
interface uart_frame_parser_if;
    logic [7:0]  i_rx_data;
    logic        i_rx_rq;
    logic [63:0] o_data;
    logic [7:0]  o_num;
    logic        o_valid;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;

    modport master (
        output i_rx_data, i_rx_rq,
        input  o_data, o_num, o_valid, o_err, o_err_code, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_rq,
        output o_data, o_num, o_valid, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Decodes HEAD, NUM, DATA_NUM payload bytes, TAIL frames from the UART receive strobe
// stream into a parallel word, flagging bad tails and inter-byte timeouts.
module uart_frame_parser #(
    parameter int unsigned DATA_NUM    = 6,
    parameter logic [7:0]  HEAD        = 8'h55,
    parameter logic [7:0]  TAIL        = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    uart_frame_parser_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NUM,
        ST_DATA,
        ST_TAIL
    } state_t;

    localparam logic [3:0]  LAST_BYTE = 4'(DATA_NUM - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

    state_t      state_q;
    logic [1:0]  rq_buf_q;
    logic [7:0]  rx_d_q;
    logic [3:0]  byte_cnt_q;
    logic [31:0] to_cnt_q;
    logic [63:0] data_shadow_q;
    logic [7:0]  num_shadow_q;
    logic [63:0] data_q;
    logic [7:0]  num_q;
    logic        valid_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic        byte_stb;
    logic        timeout;

    // A held-high request produces a single strobe on its rising edge.
    assign byte_stb = (rq_buf_q == 2'b01);
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign timeout  = (state_q != ST_IDLE) && !byte_stb && (to_cnt_q == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= ST_IDLE;
            rq_buf_q      <= 2'b00;
            rx_d_q        <= 8'h00;
            byte_cnt_q    <= 4'd0;
            to_cnt_q      <= 32'd0;
            data_shadow_q <= 64'd0;
            num_shadow_q  <= 8'h00;
            data_q        <= 64'd0;
            num_q         <= 8'h00;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            rq_buf_q <= {rq_buf_q[0], bus.i_rx_rq};
            rx_d_q   <= bus.i_rx_data;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;

            if (state_q == ST_IDLE || byte_stb) begin
                to_cnt_q <= 32'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end

            if (timeout) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b10;
                state_q    <= ST_IDLE;
            end else if (byte_stb) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_d_q == HEAD) begin
                            state_q <= ST_NUM;
                        end
                    end
                    ST_NUM: begin
                        num_shadow_q  <= rx_d_q;
                        data_shadow_q <= 64'd0;
                        byte_cnt_q    <= 4'd0;
                        state_q       <= ST_DATA;
                    end
                    ST_DATA: begin
                        data_shadow_q[{byte_cnt_q[2:0], 3'b000} +: 8] <= rx_d_q;
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_q <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        // A wrong tail byte is consumed here, never re-read as a HEAD.
                        if (rx_d_q == TAIL) begin
                            data_q  <= data_shadow_q;
                            num_q   <= num_shadow_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_num      = num_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = err_code_q;
    assign bus.o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: table of frames with expected results fed through a
// scoreboard, plus hand-timed sequences for latency, timeout, reset and back-to-back frames.
module tb_uart_frame_parser;

    localparam int unsigned DATA_NUM    = 6;
    localparam int unsigned TIMEOUT_CYC = 50;

    logic i_clk;
    logic i_rst;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .DATA_NUM    (DATA_NUM),
        .HEAD        (8'h55),
        .TAIL        (8'hAA),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // kind: 0 = no output expected, 1 = o_valid, 2 = o_err
    typedef struct packed {
        logic [4:0]   n;
        logic [127:0] fr;
        logic [1:0]   kind;
        logic [1:0]   code;
        logic [7:0]   num;
        logic [63:0]  data;
    } vec_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  code;
        logic [7:0]  num;
        logic [63:0] data;
    } exp_t;

    vec_t        vecs [8];
    exp_t        sb [$];
    int          n_chk;
    int          n_fail;
    logic [7:0]  last_num;
    logic [63:0] last_data;
    logic [1:0]  last_code;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_valid(input logic [7:0] num, input logic [63:0] data);
        sb.push_back('{kind: 2'd1, code: last_code, num: num, data: data});
        last_num  = num;
        last_data = data;
    endtask

    task automatic expect_err(input logic [1:0] code);
        sb.push_back('{kind: 2'd2, code: code, num: last_num, data: last_data});
        last_code = code;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        bus.i_rx_data = b;
        bus.i_rx_rq   = 1'b1;
        repeat (hold) @(posedge i_clk);
        #1 bus.i_rx_rq = 1'b0;
        repeat (gap) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [127:0] fr, input int n, input int hold, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte(fr[8*(n-1-i) +: 8], hold, gap);
        end
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge i_clk);
        repeat (4) @(posedge i_clk);
        #1;
        chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
        chk({nm, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({nm, "_code_hold"}, 64'(bus.o_err_code), 64'(last_code));
        sb.delete();
    endtask

    // Scoreboard consumer: every pulse must match the oldest pending expectation.
    always @(negedge i_clk) begin
        if (bus.o_valid || bus.o_err) begin
            if (bus.o_valid && bus.o_err) begin
                n_chk++;
                n_fail++;
                $display("FAIL both_pulses: o_valid and o_err high together at %0t", $time);
            end else if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%b err=%b with nothing pending at %0t",
                         bus.o_valid, bus.o_err, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", bus.o_valid ? 64'd1 : 64'd2, 64'(e.kind));
                chk("sb_num", 64'(bus.o_num), 64'(e.num));
                chk("sb_data", bus.o_data, e.data);
                if (bus.o_err) chk("sb_code", 64'(bus.o_err_code), 64'(e.code));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        last_num  = 8'h00;
        last_data = 64'd0;
        last_code = 2'b00;

        vecs[0] = '{n: 5'd9,  fr: 128'h55_02_11_22_33_44_55_66_AA,
                    kind: 2'd1, code: 2'b00, num: 8'h02, data: 64'h0000_6655_4433_2211};
        vecs[1] = '{n: 5'd12, fr: 128'h00_AA_13_55_01_A1_A2_A3_A4_A5_A6_AA,
                    kind: 2'd1, code: 2'b00, num: 8'h01, data: 64'h0000_A6A5_A4A3_A2A1};
        vecs[2] = '{n: 5'd9,  fr: 128'h55_03_01_02_03_04_05_06_BB,
                    kind: 2'd2, code: 2'b01, num: 8'h01, data: 64'h0000_A6A5_A4A3_A2A1};
        vecs[3] = '{n: 5'd9,  fr: 128'h55_07_AA_55_AA_55_AA_55_AA,
                    kind: 2'd1, code: 2'b00, num: 8'h07, data: 64'h0000_55AA_55AA_55AA};
        vecs[4] = '{n: 5'd9,  fr: 128'h55_09_10_20_30_40_50_60_55,
                    kind: 2'd2, code: 2'b01, num: 8'h07, data: 64'h0000_55AA_55AA_55AA};
        vecs[5] = '{n: 5'd8,  fr: 128'h09_11_22_33_44_56_66_AA,
                    kind: 2'd0, code: 2'b00, num: 8'h07, data: 64'h0000_55AA_55AA_55AA};
        vecs[6] = '{n: 5'd9,  fr: 128'h55_FF_00_00_00_00_00_00_AA,
                    kind: 2'd1, code: 2'b00, num: 8'hFF, data: 64'h0};
        vecs[7] = '{n: 5'd9,  fr: 128'h55_55_01_02_03_04_05_06_AA,
                    kind: 2'd1, code: 2'b00, num: 8'h55, data: 64'h0000_0605_0403_0201};

        i_rst         = 1'b0;
        bus.i_rx_rq   = 1'b0;
        bus.i_rx_data = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", bus.o_data, 64'd0);
        chk("rst_num", 64'(bus.o_num), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        chk("rst_code", 64'(bus.o_err_code), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].kind == 2'd1) expect_valid(vecs[i].num, vecs[i].data);
            if (vecs[i].kind == 2'd2) expect_err(vecs[i].code);
            send_frame(vecs[i].fr, int'(vecs[i].n), 1 + (i % 2), 1 + (i % 3));
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_num", i), 64'(bus.o_num), 64'(vecs[i].num));
            chk($sformatf("vec%0d_data", i), bus.o_data, vecs[i].data);
        end

        // Valid latency: pulse two edges after the tail request rises, one cycle wide.
        expect_valid(8'h10, 64'h0000_C6C5_C4C3_C2C1);
        send_byte(8'h55, 1, 1);
        chk("lat_busy", 64'(bus.o_busy), 64'd1);
        send_frame(128'h10_C1_C2_C3_C4_C5_C6, 7, 1, 1);
        bus.i_rx_data = 8'hAA;
        bus.i_rx_rq   = 1'b1;
        @(posedge i_clk);
        #1 chk("lat_e1", 64'(bus.o_valid), 64'd0);
        bus.i_rx_rq = 1'b0;
        @(posedge i_clk);
        #1 chk("lat_e2", 64'(bus.o_valid), 64'd1);
        @(posedge i_clk);
        #1 chk("lat_e3", 64'(bus.o_valid), 64'd0);
        drain("lat");

        // Timeout: error exactly TIMEOUT_CYC cycles after the last byte would have been consumed.
        expect_err(2'b10);
        send_byte(8'h55, 1, 1);
        send_byte(8'h04, 1, 1);
        bus.i_rx_data = 8'h01;
        bus.i_rx_rq   = 1'b1;
        @(posedge i_clk);
        #1 bus.i_rx_rq = 1'b0;
        repeat (TIMEOUT_CYC) @(posedge i_clk);
        #1 chk("to_early", 64'(bus.o_err), 64'd0);
        @(posedge i_clk);
        #1 chk("to_fire", 64'(bus.o_err), 64'd1);
        chk("to_code", 64'(bus.o_err_code), 64'd2);
        @(posedge i_clk);
        #1 chk("to_width", 64'(bus.o_err), 64'd0);
        drain("to");
        expect_valid(8'h20, 64'h0000_0C0B_0A09_0807);
        send_frame(128'h55_20_07_08_09_0A_0B_0C_AA, 9, 1, 1);
        drain("to_next");

        // A byte landing in the expiry cycle keeps the frame alive.
        expect_valid(8'h08, 64'h0000_0605_0403_0201);
        bus.i_rx_data = 8'h55;
        bus.i_rx_rq   = 1'b1;
        @(posedge i_clk);
        #1 bus.i_rx_rq = 1'b0;
        repeat (TIMEOUT_CYC - 1) @(posedge i_clk);
        #1;
        bus.i_rx_data = 8'h08;
        bus.i_rx_rq   = 1'b1;
        @(posedge i_clk);
        #1 bus.i_rx_rq = 1'b0;
        @(posedge i_clk);
        #1;
        send_frame(128'h01_02_03_04_05_06_AA, 7, 1, 1);
        drain("coincide");

        // Back-to-back frames with each request held for three cycles.
        expect_valid(8'h31, 64'h0000_1615_1413_1211);
        expect_valid(8'h32, 64'h0000_2625_2423_2221);
        send_frame(128'h55_31_11_12_13_14_15_16_AA, 9, 3, 1);
        send_frame(128'h55_32_21_22_23_24_25_26_AA, 9, 3, 1);
        drain("b2b");
        chk("b2b_num", 64'(bus.o_num), 64'h32);
        chk("b2b_data", bus.o_data, 64'h0000_2625_2423_2221);

        // Reset mid-frame: partial frame dropped, outputs cleared, next frame decoded.
        send_frame(128'h55_05_01_02, 4, 1, 1);
        #3 i_rst = 1'b0;
        #1;
        chk("mrst_data", bus.o_data, 64'd0);
        chk("mrst_num", 64'(bus.o_num), 64'd0);
        chk("mrst_code", 64'(bus.o_err_code), 64'd0);
        chk("mrst_busy", 64'(bus.o_busy), 64'd0);
        last_num  = 8'h00;
        last_data = 64'd0;
        last_code = 2'b00;
        repeat (3) @(posedge i_clk);
        #3 i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        expect_valid(8'h42, 64'h0000_F6F5_F4F3_F2F1);
        send_frame(128'h55_42_F1_F2_F3_F4_F5_F6_AA, 9, 2, 2);
        drain("mrst_next");
        chk("mrst_next_num", 64'(bus.o_num), 64'h42);
        chk("mrst_next_data", bus.o_data, 64'h0000_F6F5_F4F3_F2F1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
